// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one block-wide memory port between two cache requesters
//   (port 0 = I-cache, port 1 = D-cache). It uses round-robin arbitration and
//   allows one memory transaction in flight at a time. It pulses a one-cycle
//   ready to the served port and runs a watchdog on the memory response.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   req0/1, wr0/1         request (held until rdy) and write select per port
//   addr0/1, wdata0/1     block address / write block per port
//   rdy0/1                one-cycle completion pulse to the granted port
//   rdata                 last read block, held until the next read completes
//   Req_Low, Wr_Low       memory request / write enable (high only in ISSUE)
//   A_Low, DO_Low         memory address / write data (latched copy)
//   DI_Low, Rdy_Low       memory read data / one-cycle completion
//   busy                  high while a transaction is being handled
//   err                   sticky watchdog-abort flag, cleared only by reset
//   state_dbg             current FSM state (IDLE=0, ISSUE=1, RESP=2)
//
// Handshake: a requester raises reqN and holds reqN, wrN, addrN and wdataN
// stable until it sees rdyN high for one cycle. rdyN is a pure pulse with no
// back-pressure. On the memory side, Req_Low stays high until Rdy_Low
// arrives or the watchdog expires. Rdy_Low is honoured only while Req_Low is high.

module mem_port_arbiter #(
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               wr0,
  input  logic               wr1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [BLOCK_W-1:0] wdata0,
  input  logic [BLOCK_W-1:0] wdata1,
  output logic               rdy0,
  output logic               rdy1,
  output logic [BLOCK_W-1:0] rdata,
  output logic               Req_Low,
  output logic               Wr_Low,
  output logic [ADDR_W-1:0]  A_Low,
  output logic [BLOCK_W-1:0] DO_Low,
  input  logic [BLOCK_W-1:0] DI_Low,
  input  logic               Rdy_Low,
  output logic               busy,
  output logic               err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // This is the wd_cnt value at the start of the last ISSUE cycle that is
  // allowed. ISSUE therefore lasts at most TIMEOUT cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic               gnt;
  logic               wr_q;
  logic               rr_ptr;
  logic [1:0]         holdoff;
  logic [7:0]         wd_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;

  logic [1:0] elig;
  logic       pick;

  // The port that was just served sits out one IDLE cycle. This lets the
  // other port win even when rr_ptr would otherwise be ignored.
  always_comb begin
    elig = {req1, req0} & ~holdoff;
    pick = 1'b0;
    if (elig == 2'b11) pick = rr_ptr;
    else               pick = ~elig[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      wr_q    <= 1'b0;
      rr_ptr  <= 1'b0;
      holdoff <= 2'b00;
      wd_cnt  <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          holdoff <= 2'b00;
          if (elig != 2'b00) begin
            gnt     <= pick;
            wr_q    <= pick ? wr1 : wr0;
            addr_q  <= pick ? addr1 : addr0;
            wdata_q <= pick ? wdata1 : wdata0;
            wd_cnt  <= 8'd0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (Rdy_Low) begin
            if (!wr_q) rdata <= DI_Low;
            state <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP: begin
          rr_ptr  <= ~gnt;
          holdoff <= gnt ? 2'b10 : 2'b01;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The outputs below decode registered state only, so they are glitch-free.
  // Because state is cleared asynchronously, they also drop as soon as
  // reset is asserted.
  assign Req_Low   = (state == ISSUE);
  assign Wr_Low    = (state == ISSUE) & wr_q;
  assign A_Low     = addr_q;
  assign DO_Low    = wdata_q;
  assign rdy0      = (state == RESP) & ~gnt;
  assign rdy1      = (state == RESP) & gnt;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int BW = 128;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic          rdy0, rdy1;
  logic [BW-1:0] rdata;
  logic          Req_Low, Wr_Low;
  logic [AW-1:0] A_Low;
  logic [BW-1:0] DO_Low, DI_Low;
  logic          Rdy_Low;
  logic          busy, err;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] pat_a5, pat_d1, pat_w1, pat_junk;

  mem_port_arbiter #(.BLOCK_W(BW), .ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdy0(rdy0), .rdy1(rdy1), .rdata(rdata),
    .Req_Low(Req_Low), .Wr_Low(Wr_Low), .A_Low(A_Low), .DO_Low(DO_Low),
    .DI_Low(DI_Low), .Rdy_Low(Rdy_Low),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "time limit");
  end

  // Drive-and-sample point: the next falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5   = {16{8'hA5}};
    pat_d1   = {8{16'h1234}};
    pat_w1   = {4{32'hC0FFEE01}};
    pat_junk = {16{8'h5A}};

    // ---------------- reset held with a pending request
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 10'h005; addr1 = '0; wdata0 = '0; wdata1 = '0;
    DI_Low = '0; Rdy_Low = 1'b0;
    repeat (3) tick();
    chk1("rst_req_low", Req_Low, 1'b0);
    chk1("rst_wr_low", Wr_Low, 1'b0);
    chk1("rst_rdy0", rdy0, 1'b0);
    chk1("rst_rdy1", rdy1, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkw("rst_rdata", rdata, '0);
    chkw("rst_a_low", 128'(A_Low), '0);
    chkw("rst_do_low", DO_Low, '0);

    // ---------------- release; single read of 0x05, answered in 3rd ISSUE cycle
    rst = 1'b1;
    tick();                               // grant edge -> ISSUE cycle 1
    tick();                               // ISSUE cycle 2
    chk1("rd_req_low_c2", Req_Low, 1'b1);
    chkw("rd_a_low", 128'(A_Low), 128'(10'h005));
    chk1("rd_wr_low", Wr_Low, 1'b0);
    chk1("rd_busy", busy, 1'b1);
    chk1("rd_no_early_rdy", rdy0, 1'b0);
    tick();                               // ISSUE cycle 3: memory answers
    chk1("rd_req_low_c3", Req_Low, 1'b1);
    Rdy_Low = 1'b1; DI_Low = pat_a5;
    tick();                               // RESP
    Rdy_Low = 1'b0;
    chk1("rd_rdy0", rdy0, 1'b1);
    chk1("rd_rdy1_quiet", rdy1, 1'b0);
    chk1("rd_req_low_drop", Req_Low, 1'b0);
    chkw("rd_rdata", rdata, pat_a5);
    req0 = 1'b0;
    tick();                               // IDLE
    chk1("rd_rdy0_one_pulse", rdy0, 1'b0);
    chk1("rd_idle_busy", busy, 1'b0);
    chkw("rd_rdata_hold", rdata, pat_a5);

    // ---------------- Rdy_Low outside ISSUE is ignored
    Rdy_Low = 1'b1; DI_Low = pat_junk;
    tick();
    chk1("stray_rdy0", rdy0, 1'b0);
    chk1("stray_rdy1", rdy1, 1'b0);
    chkw("stray_rdata", rdata, pat_a5);
    Rdy_Low = 1'b0;

    // ---------------- contention after reset: port 0 first, then port 1 write
    rst = 1'b0;
    req0 = 1'b1; addr0 = 10'h011; wr0 = 1'b0;
    req1 = 1'b1; addr1 = 10'h3FF; wr1 = 1'b1; wdata1 = pat_w1;
    tick();
    rst = 1'b1;
    tick();                               // ISSUE for port 0
    chkw("ct_first_addr", 128'(A_Low), 128'(10'h011));
    chk1("ct_first_wr", Wr_Low, 1'b0);
    Rdy_Low = 1'b1; DI_Low = pat_d1;
    tick();                               // RESP port 0
    Rdy_Low = 1'b0;
    chk1("ct_rdy0", rdy0, 1'b1);
    chk1("ct_rdy1_quiet", rdy1, 1'b0);
    chkw("ct_rdata", rdata, pat_d1);
    req0 = 1'b0;
    tick();                               // IDLE, port 1 granted at next edge
    chk1("ct_gap_busy", busy, 1'b0);
    tick();                               // ISSUE for port 1 write
    chk1("ct_wr_req", Req_Low, 1'b1);
    chk1("ct_wr_wr", Wr_Low, 1'b1);
    chkw("ct_wr_addr", 128'(A_Low), 128'(10'h3FF));
    chkw("ct_wr_data", DO_Low, pat_w1);
    Rdy_Low = 1'b1; DI_Low = pat_junk;
    tick();                               // RESP port 1
    Rdy_Low = 1'b0;
    chk1("ct_rdy1", rdy1, 1'b1);
    chk1("ct_rdy0_quiet", rdy0, 1'b0);
    chkw("ct_rdata_kept", rdata, pat_d1);
    chk1("ct_wr_low_drop", Wr_Low, 1'b0);
    req1 = 1'b0; wr1 = 1'b0;

    // ---------------- fairness: both ports requesting for 6 transactions
    tick();                               // IDLE
    addr0 = 10'h0A0; addr1 = 10'h0A1;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();                             // ISSUE
      chk1("fair_req_low", Req_Low, 1'b1);
      chkw("fair_order", 128'(A_Low), (t % 2 == 1) ? 128'(10'h0A1) : 128'(10'h0A0));
      Rdy_Low = 1'b1; DI_Low = 128'(t + 1);
      tick();                             // RESP
      Rdy_Low = 1'b0;
      if (t % 2 == 1) chk1("fair_rdy1", rdy1, 1'b1);
      else            chk1("fair_rdy0", rdy0, 1'b1);
      chkw("fair_rdata", rdata, 128'(t + 1));
      if (t == 5) begin req0 = 1'b0; req1 = 1'b0; end
      tick();                             // the single IDLE cycle
      chk1("fair_gap_busy", busy, 1'b0);
    end

    // ---------------- watchdog: TIMEOUT=8, memory silent
    req0 = 1'b1; addr0 = 10'h022;
    tick();                               // ISSUE cycle 1
    repeat (7) tick();                    // ISSUE cycle 8
    chk1("wd_still_issue", Req_Low, 1'b1);
    chk1("wd_err_not_yet", err, 1'b0);
    tick();                               // RESP after abort
    chk1("wd_err_set", err, 1'b1);
    chk1("wd_rdy0", rdy0, 1'b1);
    chkw("wd_rdata_kept", rdata, 128'(6));
    req0 = 1'b0;
    tick();
    chk1("wd_err_sticky", err, 1'b1);

    // ---------------- next request is still served; same port waits one more cycle
    req1 = 1'b1; addr1 = 10'h033;
    tick();                               // ISSUE port 1
    chkw("wd_next_addr", 128'(A_Low), 128'(10'h033));
    Rdy_Low = 1'b1; DI_Low = 128'(8'h77);
    tick();                               // RESP
    Rdy_Low = 1'b0;
    chk1("wd_next_rdy1", rdy1, 1'b1);
    chkw("wd_next_rdata", rdata, 128'(8'h77));
    chk1("wd_err_kept", err, 1'b1);
    tick();                               // IDLE, port 1 held off
    chk1("same_gap1_busy", busy, 1'b0);
    tick();                               // still IDLE
    chk1("same_gap2_req", Req_Low, 1'b0);
    tick();                               // re-granted
    chk1("same_regrant", Req_Low, 1'b1);
    Rdy_Low = 1'b1; DI_Low = 128'(8'h88);
    tick();
    Rdy_Low = 1'b0;
    chk1("same_rdy1", rdy1, 1'b1);
    req1 = 1'b0;
    tick();

    // ---------------- serve port 0 so rr_ptr points at port 1
    req0 = 1'b1; addr0 = 10'h044;
    tick();
    Rdy_Low = 1'b1; DI_Low = 128'(8'h99);
    tick();
    Rdy_Low = 1'b0;
    chk1("pre_rdy0", rdy0, 1'b1);
    req0 = 1'b0;
    tick();

    // ---------------- mid-operation reset
    req1 = 1'b1; addr1 = 10'h055;
    tick();                               // ISSUE port 1
    chk1("mid_req_low", Req_Low, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("mid_req_drop", Req_Low, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_err_clr", err, 1'b0);
    Rdy_Low = 1'b1;
    @(negedge clk);
    chk1("mid_no_rdy1", rdy1, 1'b0);
    chk1("mid_no_rdy0", rdy0, 1'b0);
    Rdy_Low = 1'b0;
    req0 = 1'b1; addr0 = 10'h066;
    rst = 1'b1;
    tick();                               // both requesting: port 0 wins
    chkw("mid_rr_reset", 128'(A_Low), 128'(10'h066));
    Rdy_Low = 1'b1; DI_Low = 128'(8'hAB);
    tick();
    Rdy_Low = 1'b0;
    chk1("mid_after_rdy0", rdy0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
